// File: rtl/rv32_bpred_pkg.sv
// Shared types and constants for the rv32 bimodal/gshare branch predictor.
//   ctr_t    : 2-bit saturating direction counter
//   CTR_*    : the four counter states (strong/weak not-taken/taken)
//   state_t  : predictor FSM states (table initialisation sweep, ready)
package rv32_bpred_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/rv32_branch_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor.
// Handshake: there is no backpressure. A lookup or update is honoured in any
// cycle where its valid is high and ready_out is high; while ready_out is low
// the predictor ignores both valids. predicted_taken_out answers the lookup of
// the previous cycle (0 when that cycle had no honoured lookup).
// state exposes the predictor FSM for observation.
//   master : fetch/execute side (drives lookup_*/update_*)
//   slave  : predictor (drives ready_out, predicted_taken_out, state)
interface rv32_branch_predictor_if;
  logic                    lookup_valid_in;
  logic [31:0]             lookup_pc_in;
  logic                    update_valid_in;
  logic [31:0]             update_pc_in;
  logic                    update_taken_in;
  logic                    ready_out;
  logic                    predicted_taken_out;
  rv32_bpred_pkg::state_t  state;

  modport master (
    output lookup_valid_in, lookup_pc_in,
    output update_valid_in, update_pc_in, update_taken_in,
    input  ready_out, predicted_taken_out, state
  );

  modport slave (
    input  lookup_valid_in, lookup_pc_in,
    input  update_valid_in, update_pc_in, update_taken_in,
    output ready_out, predicted_taken_out, state
  );
endinterface

// File: rtl/rv32_bpred_counter.sv
// Combinational 2-bit saturating counter next-state function.
//   cnt      : current counter value
//   taken    : resolved direction
//   cnt_next : counter after training (saturates at 00 and 11, never wraps)
module rv32_bpred_counter
  import rv32_bpred_pkg::*;
(
  input  ctr_t cnt,
  input  logic taken,
  output ctr_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CTR_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CTR_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Branch-direction predictor: table of ENTRIES 2-bit saturating counters
// indexed by pc[IDX_W+1:2]. One lookup (1-cycle latency, registered output)
// and one training update per cycle. After reset an initialisation sweep
// writes INIT_STATE into every entry (ENTRIES cycles) before ready_out rises.
// Optional feature macro: RV32_BPRED_GSHARE_EN -- XOR an IDX_W-bit global
// history (shifted on each honoured update) into both lookup and update index.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high
//   bp    : rv32_branch_predictor_if.slave (lookup/update/ready/prediction/state)
module rv32_branch_predictor
  import rv32_bpred_pkg::*;
#(
  parameter int         ENTRIES    = 64,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                     clk,
  input  logic                     reset,
  rv32_branch_predictor_if.slave   bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  typedef logic [IDX_W-1:0] idx_t;

  state_t state, next_state;
  idx_t   sweep, sweep_next;
  ctr_t   table_q [ENTRIES];

  logic   ready;
  logic   upd_en;
  idx_t   lk_idx, upd_idx;
  ctr_t   upd_cur, upd_next;
  logic   wr_en;
  idx_t   wr_idx;
  ctr_t   wr_data;
  logic   pred_d, pred_q;

  assign ready  = (state == ST_READY);
  assign upd_en = ready & bp.update_valid_in;

`ifdef RV32_BPRED_GSHARE_EN
  idx_t hist;

  // Non-speculative history: only resolved branches shift in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= '0;
    else if (upd_en) hist <= {hist[IDX_W-2:0], bp.update_taken_in};
  end

  assign lk_idx  = bp.lookup_pc_in[IDX_W+1:2] ^ hist;
  assign upd_idx = bp.update_pc_in[IDX_W+1:2] ^ hist;
`else
  assign lk_idx  = bp.lookup_pc_in[IDX_W+1:2];
  assign upd_idx = bp.update_pc_in[IDX_W+1:2];
`endif

  // FSM: state register plus sweep pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      sweep <= '0;
    end else begin
      state <= next_state;
      sweep <= sweep_next;
    end
  end

  always_comb begin
    next_state = state;
    sweep_next = sweep;
    case (state)
      ST_INIT: begin
        sweep_next = sweep + idx_t'(1);
        if (sweep == idx_t'(ENTRIES - 1)) next_state = ST_READY;
      end
      ST_READY: next_state = ST_READY;
      default:  next_state = ST_INIT;
    endcase
  end

  // Training path: read-modify-write of the resolved branch's counter.
  assign upd_cur = table_q[upd_idx];

  rv32_bpred_counter u_counter (
    .cnt      (upd_cur),
    .taken    (bp.update_taken_in),
    .cnt_next (upd_next)
  );

  // The sweep owns the single write port while initialising.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_idx;
    wr_data = upd_next;
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = sweep;
      wr_data = INIT_STATE;
    end else if (upd_en) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

  // Write-first: a same-cycle update to the looked-up entry is bypassed.
  always_comb begin
    pred_d = 1'b0;
    if (ready && bp.lookup_valid_in) begin
      if (upd_en && (upd_idx == lk_idx)) pred_d = upd_next[1];
      else                               pred_d = table_q[lk_idx][1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pred_q <= 1'b0;
    else       pred_q <= pred_d;
  end

  assign bp.predicted_taken_out = pred_q;
  assign bp.ready_out           = ready;
  assign bp.state               = state;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lookup_pc_in[31:IDX_W+2], bp.lookup_pc_in[1:0],
                            bp.update_pc_in[31:IDX_W+2], bp.update_pc_in[1:0]};

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Self-checking bench for rv32_branch_predictor (ENTRIES = 64).
// Expected predictions come from a reference counter table kept in the bench;
// each driven cycle pushes its expected prediction, popped after the edge.
module tb_rv32_branch_predictor;

  localparam int ENTRIES = 64;

  logic clk;
  logic reset;

  rv32_branch_predictor_if bp ();

  rv32_branch_predictor #(
    .ENTRIES    (ENTRIES),
    .INIT_STATE (2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [0:0] exp_q[$];
  logic [1:0] model [ENTRIES];
  logic [5:0] hist_m;
  int         n_edges;
  int         check_cnt;
  int         pass_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model[i] = 2'b01;
    hist_m  = '0;
    n_edges = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bp.lookup_valid_in = 1'b0;
    bp.lookup_pc_in    = '0;
    bp.update_valid_in = 1'b0;
    bp.update_pc_in    = '0;
    bp.update_taken_in = 1'b0;
  endtask

  // Asserts reset between edges, checks the asynchronous drop, then releases.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    idle_inputs();
    #1;
    check_eq({tag, "_ready"}, {31'd0, bp.ready_out}, 32'd0);
    check_eq({tag, "_pred"},  {31'd0, bp.predicted_taken_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle of traffic: compute expectation, drive, clock, compare.
  task automatic drive_cycle(input logic lv, input logic [31:0] lpc,
                             input logic uv, input logic [31:0] upc, input logic ut);
    logic [5:0] li, ui;
    logic       rdy;
    logic       exp_pred;
    logic [0:0] popped;
    rdy = (n_edges >= ENTRIES);
    li  = lpc[7:2];
    ui  = upc[7:2];
`ifdef RV32_BPRED_GSHARE_EN
    li = li ^ hist_m;
    ui = ui ^ hist_m;
`endif
    if (rdy && uv) begin
      if (ut && model[ui] != 2'b11)       model[ui] = model[ui] + 2'b01;
      else if (!ut && model[ui] != 2'b00) model[ui] = model[ui] - 2'b01;
`ifdef RV32_BPRED_GSHARE_EN
      hist_m = {hist_m[4:0], ut};
`endif
    end
    exp_pred = (rdy && lv) ? model[li][1] : 1'b0;
    exp_q.push_back(exp_pred);

    bp.lookup_valid_in = lv;
    bp.lookup_pc_in    = lpc;
    bp.update_valid_in = uv;
    bp.update_pc_in    = upc;
    bp.update_taken_in = ut;
    @(posedge clk);
    #1;
    n_edges++;
    check_eq("ready", {31'd0, bp.ready_out}, (n_edges >= ENTRIES) ? 32'd1 : 32'd0);
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      popped = exp_q.pop_front();
      check_eq("pred", {31'd0, bp.predicted_taken_out}, {31'd0, popped});
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic t);
    drive_cycle(1'b0, 32'h0, 1'b1, pc, t);
  endtask

  task automatic look(input logic [31:0] pc);
    drive_cycle(1'b1, pc, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                  1'($urandom_range(0, 1)));
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    reset     = 1'b1;
    idle_inputs();
    model_reset();

    do_reset("por");

    // Init sweep with random traffic: ready stays low for 64 edges, lookups
    // answer 0 and updates must not disturb the initialised counters.
    random_cycles(ENTRIES);
    look(32'h100);
    look(32'h104);

    // Two taken -> predicts taken; neighbour unaffected.
    upd(32'h100, 1'b1);
    upd(32'h100, 1'b1);
    look(32'h100);
    look(32'h104);

    // Saturation at 11, then hysteresis on the way down.
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1);
    upd(32'h100, 1'b0);
    look(32'h100);
    upd(32'h100, 1'b0);
    look(32'h100);
    for (int i = 0; i < 8; i++) upd(32'h100, 1'b0);
    upd(32'h100, 1'b1);
    look(32'h100);

    // Aliasing: 0x200 and 0x100 share index 0.
    upd(32'h200, 1'b1);
    upd(32'h200, 1'b1);
    look(32'h100);

    // Same-cycle update and lookup: write-first bypass.
    drive_cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1);
    look(32'h40);

`ifdef RV32_BPRED_GSHARE_EN
    // Build history 000001 then train 0x104, which lands on entry 0.
    do_reset("gs");
    random_cycles(ENTRIES);
    upd(32'h80, 1'b1);
    upd(32'h104, 1'b1);
    upd(32'h104, 1'b1);
    for (int i = 0; i < 8; i++) look(32'($urandom_range(0, 63)) << 2);
`endif

    // Mixed random traffic with frequent index collisions.
    random_cycles(300);

    // Leave a taken prediction on the output, then reset mid-traffic.
    for (int i = 0; i < 4; i++) upd(32'h300, 1'b1);
    drive_cycle(1'b1, 32'h300, 1'b1, 32'h300, 1'b1);
    do_reset("rst_mid");
    random_cycles(20);

    // Reset mid-sweep: the sweep must restart at entry 0.
    do_reset("rst_sweep");
    random_cycles(ENTRIES);
    look(32'h300);
    look(32'h100);
    look(32'h40);
    random_cycles(100);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
